// File: rtl/transform_pkg.sv
// Shared definitions for the transform UART transmit path: EOL characters
// and the state encodings of the pair sequencer and the byte serializer.
package transform_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        LHS,
        RHS,
        CR,
        LF
    } seqState_t;

    typedef enum logic [1:0] {
        START,
        DATA,
        STOP
    } serState_t;

endpackage

// File: rtl/uart_byte_tx.sv
// One UART 8N1 frame per start pulse, LSB first. A start pulse landing on the
// done cycle chains the next frame with no idle bit in between.
module uart_byte_tx
    import transform_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_active;
    serState_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             r_tx;

    assign o_done = r_active && (r_state == STOP) && (r_cnt == LAST_CNT);
    assign o_tx   = r_tx;

    // The line level is computed one bit ahead so tx comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_state  <= START;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_state  <= START;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= i_data;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (r_cnt == LAST_CNT) begin
                r_cnt <= '0;
                unique case (r_state)
                    START: begin
                        r_state  <= DATA;
                        r_bitIdx <= '0;
                        r_tx     <= r_shift[0];
                    end
                    DATA: begin
                        if (r_bitIdx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end
                    STOP: begin
                        r_active <= 1'b0;
                        r_tx     <= 1'b1;
                    end
                    default: r_state <= START;
                endcase
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/transform_uart_tx.sv
// Serializes each (lhs, rhs) character pair as two UART frames and, after a
// pair that ends a line, optionally appends CR LF.
module transform_uart_tx
    import transform_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit EOL_ENABLE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pair_valid,
    output logic       pair_ready,
    input  logic [7:0] pair_lhs,
    input  logic [7:0] pair_rhs,
    input  logic       pair_last,
    output logic       tx,
    output logic       busy,
    output logic       line_done
);

    seqState_t  r_state;
    seqState_t  w_nextState;
    logic [7:0] r_rhs;
    logic       r_last;
    logic       r_ready;
    logic       r_busy;
    logic       r_lineDone;
    logic       w_accept;
    logic       w_start;
    logic       w_done;
    logic [7:0] w_byte;

    assign w_accept = pair_valid && r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_nextState = LHS;
            LHS:  if (w_done) w_nextState = RHS;
            RHS:  if (w_done) w_nextState = (r_last && EOL_ENABLE) ? CR : IDLE;
            CR:   if (w_done) w_nextState = LF;
            LF:   if (w_done) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // lhs is fed straight from the input on the accept edge; later bytes come from the latch.
    always_comb begin
        w_start = w_accept || (w_done && (w_nextState != IDLE));
        w_byte  = 8'h00;
        unique case (w_nextState)
            LHS:     w_byte = pair_lhs;
            RHS:     w_byte = r_rhs;
            CR:      w_byte = ASCII_CR;
            LF:      w_byte = ASCII_LF;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rhs  <= 8'h00;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_rhs  <= pair_rhs;
            r_last <= pair_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_lineDone <= 1'b0;
        end else begin
            r_ready    <= (w_nextState == IDLE);
            r_busy     <= (w_nextState != IDLE);
            r_lineDone <= (r_state != IDLE) && (w_nextState == IDLE) && r_last;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byteTx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_data (w_byte),
        .o_tx   (tx),
        .o_done (w_done)
    );

    assign pair_ready = r_ready;
    assign busy       = r_busy;
    assign line_done  = r_lineDone;

endmodule
